// File: rtl/pia_bus_pkg.sv
// Shared types and constants for the two-requester 6821 PIA bus arbiter.
package pia_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } pia_state_e;

  localparam logic [1:0] PIA_RS_DA = 2'b00;
  localparam logic [1:0] PIA_RS_CA = 2'b01;
  localparam logic [1:0] PIA_RS_DB = 2'b10;
  localparam logic [1:0] PIA_RS_CB = 2'b11;

  localparam int unsigned PIA_E_DIV_DEFAULT = 12;

  // One requester's access as seen at grant time.
  typedef struct packed {
    logic       we;
    logic [1:0] rs;
    logic [7:0] wdata;
  } pia_req_t;

endpackage

// File: rtl/pia_e_strobe_gen.sv
// Free-running E strobe: counts 0..E_DIV-1 and ticks for one cycle on the last count.
module pia_e_strobe_gen
  import pia_bus_pkg::*;
#(
  parameter int unsigned E_DIV = PIA_E_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic e_tick
);

  localparam int unsigned   CW   = $clog2(E_DIV);
  localparam logic [CW-1:0] LAST = CW'(E_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // NOTE: give every always_comb output a value before any branch, so no path infers a latch.
  always_comb begin
    count_d = count_q + 1'b1;
    if (count_q == LAST) count_d = '0;
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign e_tick = (count_q == LAST);

endmodule

// File: rtl/pia_bus_arbiter.sv
// Two-requester access arbiter and E strobe source for one 6821-style PIA.
// Define PIA_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 has fixed priority.
module pia_bus_arbiter
  import pia_bus_pkg::*;
#(
  parameter int unsigned E_DIV = PIA_E_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] rs0,
  input  logic [1:0] rs1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       pia_e,
  output logic       pia_cs,
  output logic [1:0] pia_rs,
  output logic       pia_r_w_n,
  output logic [7:0] pia_wdata,
  input  logic [7:0] pia_rdata
);

  pia_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       setup_ok_q, setup_ok_d;
  logic       cs_q, cs_d;
  logic [1:0] rs_q, rs_d;
  logic       rwn_q, rwn_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;

  logic       e_tick;
  logic       any_req;
  logic       grant_now;
  logic       win_sel;
  pia_req_t   req_sel;

  pia_e_strobe_gen #(.E_DIV(E_DIV)) u_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .e_tick (e_tick)
  );

  assign any_req   = req0 | req1;
  assign grant_now = (state_q == IDLE) && any_req;

`ifdef PIA_ARB_ROUND_ROBIN_EN
  // rr_ptr_q names the requester that wins the next tie.
  logic rr_ptr_q, rr_ptr_d;

  assign win_sel  = (req0 && req1) ? rr_ptr_q : req1;
  assign rr_ptr_d = grant_now ? ~win_sel : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  assign win_sel = ~req0;
`endif

  assign req_sel = win_sel ? {we1, rs1, wdata1} : {we0, rs0, wdata0};

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    setup_ok_d = setup_ok_q;
    cs_d       = cs_q;
    rs_d       = rs_q;
    rwn_d      = rwn_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_now) begin
          state_d    = ACTIVE;
          grant_d    = win_sel;
          cs_d       = 1'b1;
          rs_d       = req_sel.rs;
          rwn_d      = ~req_sel.we;
          wdata_d    = req_sel.wdata;
          setup_ok_d = 1'b0;
        end
      end
      ACTIVE: begin
        // The bus became valid at the grant edge, so a strobe in the first
        // ACTIVE cycle would violate PIA setup; it is skipped.
        setup_ok_d = 1'b1;
        if (e_tick && setup_ok_q) begin
          state_d = DONE;
          cs_d    = 1'b0;
          rwn_d   = 1'b1;
          if (rwn_q) rdata_d = pia_rdata;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      setup_ok_q <= 1'b0;
      cs_q       <= 1'b0;
      rs_q       <= PIA_RS_DA;
      rwn_q      <= 1'b1;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      setup_ok_q <= setup_ok_d;
      cs_q       <= cs_d;
      rs_q       <= rs_d;
      rwn_q      <= rwn_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  assign pia_e     = e_tick;
  assign pia_cs    = cs_q;
  assign pia_rs    = rs_q;
  assign pia_r_w_n = rwn_q;
  assign pia_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/pia_bus_arbiter.md
# pia_bus_arbiter

Shares one 6821-style PIA host interface between two bus requesters (e.g. CPU decode and a self-test/initialisation sequencer) and generates the free-running E strobe that the PIA uses for register writes, control-line edge detection and read side effects. Each access is latched at grant, presented to the PIA with at least one cycle of setup, and completed on an E strobe; the requester then gets a one-cycle acknowledge with read data. It sits between address decode and the PIA instance.

## Interface
- E_DIV, 12: clk cycles per E period; legal range 2..255.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  access request, level, held until ack.
- we0 / we1  in  1  1 = write, 0 = read.
- rs0 / rs1  in  2  PIA register select.
- wdata0 / wdata1  in  8  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata  out  8  read data, valid while ack0/ack1 is high, held until the next completed read.
- busy  out  1  access in progress (ACTIVE or DONE).
- pia_e  out  1  E strobe to the PIA enable input; one cycle high every E_DIV cycles.
- pia_cs  out  1  chip select.
- pia_rs  out  2  register select.
- pia_r_w_n  out  1  1 = read.
- pia_wdata  out  8  data to the PIA.
- pia_rdata  in  8  data from the PIA; combinational on pia_cs/pia_rs.

## Operation
- Strobe counter runs 0..E_DIV-1 continuously, independent of accesses. pia_e=1 only when count==E_DIV-1, then count wraps to 0. The strobe never stops, so PIA edge detection keeps running.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE: if any req is high, pick a winner, latch its we/rs/wdata into the pia_* outputs, set pia_cs=1, clear setup_ok, go to ACTIVE. The other requester waits.
- ACTIVE: pia_cs, pia_rs, pia_r_w_n and pia_wdata are stable.
  - The first ACTIVE cycle sets setup_ok and never strobes the access, even if pia_e=1.
  - The access completes on the first cycle with pia_e=1 and setup_ok=1. On a read, rdata<=pia_rdata in that same cycle. Next state is DONE.
- DONE: pia_cs=0, pia_r_w_n=1, ack of the winner =1 for exactly this cycle. Next state is IDLE.
- Requester rule: deassert req on the edge at which ack is sampled high. A req still high in the next IDLE cycle is a new access.
- Dropping req while ACTIVE does not abort the access (reads clear PIA IRQ flags). The access completes and ack still pulses.
- Arbitration, both req high in IDLE: winner per Configuration.
- pia_cs is low in IDLE and DONE, so PIA read side effects (IRQ clear, CA2/CB2 handshakes) occur only for granted accesses.

## Timing
- Reset values: pia_e=0, pia_cs=0, pia_rs=0, pia_r_w_n=1, pia_wdata=0, ack0=ack1=0, rdata=0, busy=0, counter=0, state=IDLE, RR pointer favours requester 0.
- Reset asserted mid-access: the access is abandoned, no ack, pia_cs drops asynchronously.
- Latency from req high (in IDLE) to ack high: minimum 3 cycles, maximum E_DIV+2 cycles.
- Setup: pia_rs/pia_r_w_n/pia_wdata/pia_cs are valid at least one full clk before the pia_e cycle. Hold: they stay valid through the pia_e cycle.
- Throughput: at most one access per E period.
- Counter wrap: E_DIV-1 → 0. With E_DIV=2, an access entering ACTIVE on a strobe cycle completes on the following strobe.

## Configuration
- PIA_ARB_ROUND_ROBIN_EN defined: round-robin. The requester not granted last wins a tie; the pointer updates at grant.
- Not defined: fixed priority, req0 always beats req1. The pointer logic is not built.

## Structure
- Package pia_bus_pkg holds:
  - the state enum (IDLE/ACTIVE/DONE);
  - RS constants PIA_RS_DA=2'b00, PIA_RS_CA=2'b01, PIA_RS_DB=2'b10, PIA_RS_CB=2'b11;
  - default E_DIV.
- Sub-module pia_e_strobe_gen: parameter E_DIV, ports clk, rst_n, e_tick.
- Arbiter, FSM and the latched outputs stay in the top module.

## Test plan
- Single write: E_DIV=4, req0 with we0=1, rs0=2'b01, wdata0=8'h04. Expect pia_cs high with pia_rs=01, pia_wdata=04, pia_r_w_n=0 through exactly one pia_e, then a single ack0 pulse, with latency 3..6 cycles.
- Single read: req1 read rs1=2'b00, pia_rdata driven 8'hA5 during the strobe. Expect ack1 with rdata=A5, and rdata holding A5 afterwards.
- Setup guard: launch a request so ACTIVE is entered on a pia_e cycle. Expect no strobe in that cycle and completion on the next pia_e (E_DIV+2 latency).
- Contention: req0 and req1 held continuously for 4 accesses.
  - RR build: grants alternate 0,1,0,1.
  - Fixed build: grant 0 every time.
  - Never two acks in one cycle.
- Abandon: drop req0 mid-ACTIVE. Expect the access still completes and ack0 pulses once.
- Async reset: assert rst_n low during ACTIVE. Expect pia_cs=0, busy=0, no ack, and a counter restart at 0 after release.
